// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer for an async FIFO: pops first-word-fall-through words into a
// 2-entry skid buffer and presents them on a valid/ready stream, with a drain-flush mode.
module async_fifo_rd_stream #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic               rempty,
  input  logic [WIDTH-1:0]   rdata,
  output logic               rinc,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  input  logic               flush,
  output logic               flushing,
  output logic [COUNT_W-1:0] word_cnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             r_state;
  logic [1:0]         r_occ;
  logic [WIDTH-1:0]   r_head;
  logic [WIDTH-1:0]   r_tail;
  logic [COUNT_W-1:0] r_word_cnt;

  logic w_run;
  logic w_full;
  logic w_rinc;
  logic w_valid;
  logic w_beat;

  assign w_run   = (r_state == ST_RUN);
  assign w_full  = (r_occ == 2'd2);
  // The pop request only looks at local state and rempty, never at m_ready;
  // it is also held low while reset is asserted so the FIFO is never popped then.
  assign w_rinc  = rrst_n && !rempty && (!w_run || !w_full);
  assign w_valid = w_run && (r_occ != 2'd0);
  assign w_beat  = w_valid && m_ready;

  assign rinc     = w_rinc;
  assign m_valid  = w_valid;
  assign m_data   = r_head;
  assign flushing = (r_state == ST_FLUSH);
  assign word_cnt = r_word_cnt;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state    <= ST_RUN;
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_beat) begin
        r_word_cnt <= r_word_cnt + CNT_ONE;
      end
      case (r_state)
        ST_RUN: begin
          if (flush) begin
            r_state <= ST_FLUSH;
            r_occ   <= 2'd0;
          end else begin
            case ({w_rinc, w_beat})
              2'b10: begin
                if (r_occ == 2'd0) begin
                  r_head <= rdata;
                end else begin
                  r_tail <= rdata;
                end
                r_occ <= r_occ + 2'd1;
              end
              2'b01: begin
                r_head <= r_tail;
                r_occ  <= r_occ - 2'd1;
              end
              2'b11: begin
                // Push and pop together: occupancy holds, head advances.
                if (w_full) begin
                  r_head <= r_tail;
                  r_tail <= rdata;
                end else begin
                  r_head <= rdata;
                end
              end
              default: begin
              end
            endcase
          end
        end
        ST_FLUSH: begin
          if (!flush && rempty) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed bench for async_fifo_rd_stream: a queue stands in for the FIFO read port,
// every comparison is an immediate assertion against hand-derived values.
module tb_async_fifo_rd_stream;

  logic       rclk = 1'b0;
  always #5 rclk = ~rclk;

  logic       rrst_n, rempty, rinc, m_valid, m_ready, flush, flushing;
  logic [7:0] rdata, m_data;
  logic [15:0] word_cnt;

  logic       rrst2_n, rempty2, rinc2, m_valid2, m_ready2, flush2, flushing2;
  logic [7:0] rdata2, m_data2;
  logic [3:0] word_cnt2;

  async_fifo_rd_stream #(.WIDTH(8), .COUNT_W(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .flush(flush),
    .flushing(flushing), .word_cnt(word_cnt)
  );

  async_fifo_rd_stream #(.WIDTH(8), .COUNT_W(4)) dut_wrap (
    .rclk(rclk), .rrst_n(rrst2_n), .rempty(rempty2), .rdata(rdata2), .rinc(rinc2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .flush(flush2),
    .flushing(flushing2), .word_cnt(word_cnt2)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc_n  = 0;
  int         pops   = 0;
  int         n2     = 0;
  logic [7:0] fq[$];
  logic [7:0] obs[$];
  int         beat_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs_at(input int i);
    return (obs.size() > i) ? obs[i] : 8'hxx;
  endfunction

  task automatic settle();
    rempty  = (fq.size() == 0);
    rdata   = (fq.size() == 0) ? 8'h00 : fq[0];
    rempty2 = (n2 == 0);
    rdata2  = 8'(n2);
    #1;
  endtask

  task automatic cyc();
    logic       s_rinc, s_beat, s_rinc2;
    logic [7:0] s_d;
    settle();
    check("no_rinc_when_empty", 32'(rinc & rempty), 32'd0);
    check("wrap_no_rinc_when_empty", 32'(rinc2 & rempty2), 32'd0);
    s_rinc  = rinc;
    s_beat  = m_valid & m_ready;
    s_d     = m_data;
    s_rinc2 = rinc2;
    @(posedge rclk);
    #1;
    cyc_n++;
    if (s_rinc && fq.size() > 0) begin
      void'(fq.pop_front());
      pops++;
    end
    if (s_beat) begin
      obs.push_back(s_d);
      beat_cyc.push_back(cyc_n);
    end
    if (s_rinc2 && n2 > 0) n2--;
  endtask

  initial begin
    rrst_n = 1'b0; rrst2_n = 1'b0;
    m_ready = 1'b0; flush = 1'b0; m_ready2 = 1'b1; flush2 = 1'b0;
    // T1: reset held with a non-empty FIFO
    fq.push_back(8'hEE);
    settle();
    check("t1_rinc", 32'(rinc), 32'd0);
    check("t1_m_valid", 32'(m_valid), 32'd0);
    check("t1_word_cnt", 32'(word_cnt), 32'd0);
    check("t1_m_data", 32'(m_data), 32'd0);
    check("t1_flushing", 32'(flushing), 32'd0);
    repeat (3) cyc();
    check("t1_rinc_held", 32'(rinc), 32'd0);
    check("t1_fifo_untouched", 32'(fq.size()), 32'd1);
    fq.delete();
    rrst_n = 1'b1; rrst2_n = 1'b1; n2 = 17;
    settle();
    check("t1_rinc_after_rel", 32'(rinc), 32'd0);
    check("t1_m_valid_after_rel", 32'(m_valid), 32'd0);

    // T2: single word latency
    m_ready = 1'b1;
    fq.push_back(8'hA5);
    settle();
    check("t2_rinc", 32'(rinc), 32'd1);
    check("t2_m_valid_before", 32'(m_valid), 32'd0);
    cyc(); settle();
    check("t2_m_valid", 32'(m_valid), 32'd1);
    check("t2_m_data", 32'(m_data), 32'hA5);
    check("t2_rinc_after", 32'(rinc), 32'd0);
    check("t2_rempty", 32'(rempty), 32'd1);
    cyc(); settle();
    check("t2_word_cnt", 32'(word_cnt), 32'd1);
    check("t2_m_valid_done", 32'(m_valid), 32'd0);
    check("t2_obs", 32'(obs_at(0)), 32'hA5);

    // T3: 64-word stream at full throughput
    obs.delete(); beat_cyc.delete();
    for (int i = 0; i < 64; i++) fq.push_back(8'(i));
    for (int k = 0; k < 200 && obs.size() < 64; k++) cyc();
    check("t3_beats", 32'(obs.size()), 32'd64);
    for (int i = 0; i < 64; i++) check("t3_order", 32'(obs_at(i)), 32'(i));
    if (beat_cyc.size() == 64) check("t3_back_to_back", 32'(beat_cyc[63] - beat_cyc[0]), 32'd63);
    else check("t3_back_to_back", 32'(beat_cyc.size()), 32'd64);
    settle();
    check("t3_word_cnt", 32'(word_cnt), 32'd65);
    check("t3_rempty", 32'(rempty), 32'd1);
    check("t6_wrap_word_cnt", 32'(word_cnt2), 32'd1);
    check("t6_wrap_idle", 32'(m_valid2), 32'd0);

    // T4: backpressure
    obs.delete(); pops = 0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h10 + i));
    repeat (10) cyc();
    settle();
    check("t4_m_data_mid", 32'(m_data), 32'h10);
    repeat (10) cyc();
    settle();
    check("t4_pops", 32'(pops), 32'd2);
    check("t4_m_valid", 32'(m_valid), 32'd1);
    check("t4_m_data", 32'(m_data), 32'h10);
    check("t4_rinc_full", 32'(rinc), 32'd0);
    check("t4_no_beats", 32'(obs.size()), 32'd0);
    m_ready = 1'b1;
    for (int k = 0; k < 40 && obs.size() < 8; k++) cyc();
    check("t4_beats", 32'(obs.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t4_order", 32'(obs_at(i)), 32'(8'h10 + i));
    repeat (2) cyc();
    check("t4_no_dup", 32'(obs.size()), 32'd8);
    check("t4_word_cnt", 32'(word_cnt), 32'd73);
    check("t4_pops_total", 32'(pops), 32'd8);

    // T5: flush with a beat on the flush edge
    obs.delete();
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h20 + i));
    for (int k = 0; k < 20 && obs.size() < 2; k++) cyc();
    check("t5_pre_beats", 32'(obs.size()), 32'd2);
    flush = 1'b1;
    repeat (3) begin
      cyc();
      check("t5_flushing", 32'(flushing), 32'd1);
      check("t5_m_valid", 32'(m_valid), 32'd0);
    end
    flush = 1'b0;
    for (int k = 0; k < 20 && flushing; k++) begin
      cyc();
      check("t5_m_valid_drain", 32'(m_valid), 32'd0);
    end
    check("t5_flushing_end", 32'(flushing), 32'd0);
    check("t5_fifo_drained", 32'(fq.size()), 32'd0);
    check("t5_beats", 32'(obs.size()), 32'd3);
    check("t5_edge_beat", 32'(obs_at(2)), 32'h22);
    check("t5_word_cnt", 32'(word_cnt), 32'd76);
    fq.push_back(8'h5A);
    for (int k = 0; k < 10 && obs.size() < 4; k++) cyc();
    check("t5_new_word", 32'(obs_at(3)), 32'h5A);
    check("t5_word_cnt_new", 32'(word_cnt), 32'd77);

    // T6: reset asserted with occ=2
    obs.delete(); m_ready = 1'b0;
    fq.push_back(8'h61); fq.push_back(8'h62); fq.push_back(8'h63);
    repeat (4) cyc();
    settle();
    check("t6_m_valid_full", 32'(m_valid), 32'd1);
    check("t6_m_data_full", 32'(m_data), 32'h61);
    check("t6_rinc_full", 32'(rinc), 32'd0);
    rrst_n = 1'b0;
    #1;
    check("t6_rst_m_valid", 32'(m_valid), 32'd0);
    check("t6_rst_rinc", 32'(rinc), 32'd0);
    check("t6_rst_m_data", 32'(m_data), 32'd0);
    check("t6_rst_word_cnt", 32'(word_cnt), 32'd0);
    @(posedge rclk);
    #1;
    fq.delete();
    rrst_n = 1'b1;
    repeat (2) cyc();
    settle();
    check("t6_empty_after_rel", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    fq.push_back(8'h77);
    for (int k = 0; k < 10 && obs.size() < 1; k++) cyc();
    check("t6_first_after_rel", 32'(obs_at(0)), 32'h77);
    check("t6_count_after_rel", 32'(obs.size()), 32'd1);
    check("t6_word_cnt_after_rel", 32'(word_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
